ped_call_scheduler: RTL

- Front-end scheduler for the intersection light controller's pedestrian-request input.
- Synchronizes and debounces four raw crosswalk buttons, latches calls, and presents them to the light controller as a held request.
- Detects service from the controller's pedestrian-light output, retires the served calls, and then enforces a vehicle-priority cooldown before any new request.
- Sits between the board buttons and the light controller; its request output drives the controller's pedestrian-button input directly.

---
 rtl/ped_call_scheduler.sv | 83 ++++++++
 1 files changed

// File: rtl/ped_call_scheduler.sv
// ped_call_scheduler: debounces crosswalk buttons, latches calls, holds a request until served, then enforces a cooldown
module ped_call_scheduler #(
  parameter int CYCLES_PER_SEC  = 125000000,
  parameter int DEBOUNCE_CYCLES = 1250000,
  parameter int COOLDOWN_SEC    = 20,
  parameter int REQ_TIMEOUT_SEC = 30
) (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_ped_buttons,
  input  logic       i_ped_light,
  input  logic       i_maintenance,
  output logic [3:0] o_ped_request,
  output logic [3:0] o_pending,
  output logic [3:0] o_served_mask,
  output logic       o_served_valid,
  output logic       o_fault,
  output logic [1:0] o_state
);
  typedef enum logic [1:0] {IDLE, REQ, SERVE, COOLDOWN} state_t;
  localparam longint unsigned REQ_LIM  = 64'(REQ_TIMEOUT_SEC) * 64'(CYCLES_PER_SEC);
  localparam longint unsigned COOL_LIM = 64'(COOLDOWN_SEC) * 64'(CYCLES_PER_SEC);
  localparam longint unsigned LOW_LIM  = 64'(CYCLES_PER_SEC);
  localparam longint unsigned MAX_LIM  = REQ_LIM > COOL_LIM ? REQ_LIM : COOL_LIM;
  localparam int TW = $clog2(MAX_LIM > LOW_LIM ? MAX_LIM : LOW_LIM);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [TW-1:0] REQ_L  = TW'(REQ_LIM - 1);
  localparam logic [TW-1:0] COOL_L = TW'(COOL_LIM - 1);
  localparam logic [TW-1:0] LOW_L  = TW'(LOW_LIM - 1);
  localparam logic [DW-1:0] DEB_L  = DW'(DEBOUNCE_CYCLES - 1);
  state_t state, state_n;
  logic [3:0] s1, s2, deb, deb_d, rise, served_set;
  logic [DW-1:0] dcnt [4];
  logic [TW-1:0] tmr;
  logic done, timeout;
  assign o_state = state;
  always_comb begin
    rise = deb & ~deb_d;
    done = !i_maintenance && state == SERVE && !i_ped_light && tmr == LOW_L;
    timeout = !i_maintenance && state == REQ && !i_ped_light && tmr == REQ_L;
    state_n = i_maintenance ? IDLE :
              state == IDLE  ? (o_pending != '0 ? REQ : IDLE) :
              state == REQ   ? (i_ped_light ? SERVE : timeout ? IDLE : REQ) :
              state == SERVE ? (done ? COOLDOWN : SERVE) :
              (tmr == COOL_L ? IDLE : COOLDOWN);
    o_ped_request = state == REQ ? o_pending : '0;
  end
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      s1 <= '0;
      s2 <= '0;
      deb <= '0;
      deb_d <= '0;
      for (int i = 0; i < 4; i++) dcnt[i] <= '0;
      state <= IDLE;
      tmr <= '0;
      served_set <= '0;
      o_pending <= '0;
      o_served_mask <= '0;
      o_served_valid <= 1'b0;
      o_fault <= 1'b0;
    end else begin
      s1 <= i_ped_buttons;
      s2 <= s1;
      deb_d <= deb;
      for (int i = 0; i < 4; i++) begin
        if (s2[i] == deb[i]) dcnt[i] <= '0;
        else if (dcnt[i] == DEB_L) begin
          deb[i] <= s2[i];
          dcnt[i] <= '0;
        end else dcnt[i] <= dcnt[i] + 1'b1;
      end
      state <= state_n;
      o_served_valid <= done;
      tmr <= (state_n != state || state == IDLE || (state == SERVE && i_ped_light)) ? '0 : tmr + 1'b1;
      if (i_maintenance) o_pending <= '0;
      else o_pending <= done ? (o_pending & ~served_set) | rise : o_pending | rise;
      if (state == REQ && i_ped_light && !i_maintenance) served_set <= o_pending | rise;
      if (done) o_served_mask <= served_set;
      if (timeout) o_fault <= 1'b1;
    end
  end
endmodule
